// File: rtl/rom_loader.sv
// rom_loader: turns the hps_io ioctl download stream into a region-addressed
// byte stream for boot-bundle regions and the cartridge ROM.
//
// A download with index BOOT_INDEX is split across REGIONS boot regions using
// the ascending exclusive end offsets in REGION_END. A download with index
// CART_INDEX goes to the cartridge destination (the top select bit). Accepted
// bytes pass through a 2-entry FIFO; IOCTL backpressure is asserted whenever
// the FIFO holds anything.
//
// Ports:
//   clk_sys         sole clock, rising edge
//   resb            synchronous active-low reset
//   ioctl_download  download in progress (from hps_io)
//   ioctl_index     download index, latched when a download starts
//   ioctl_wr        byte strobe
//   ioctl_addr      25-bit byte offset within the download
//   ioctl_dout      byte value
//   ioctl_wait      backpressure to hps_io (FIFO not empty)
//   rominit_active  download in progress; holds the system in reset
//   rominit_sel     one-hot destination, bit REGIONS = cartridge, 0 when idle
//   rominit_addr    region-relative byte address
//   rominit_data    byte value
//   rominit_valid   head entry available
//   rominit_ready   consumer accepts the head entry
//   cart_size       highest accepted cartridge address + 1
//   cart_size_valid one-cycle pulse when a cartridge download completes
//   rominit_err     sticky: a byte was dropped (out of range or FIFO full)

module rom_loader #(
  parameter int                    REGIONS    = 3,
  parameter int                    AW         = 17,
  parameter logic [REGIONS*25-1:0] REGION_END = {25'h2400, 25'h1400, 25'h1000},
  parameter logic [7:0]            BOOT_INDEX = 8'd0,
  parameter logic [7:0]            CART_INDEX = 8'd1
) (
  input  logic             clk_sys,
  input  logic             resb,
  input  logic             ioctl_download,
  input  logic [7:0]       ioctl_index,
  input  logic             ioctl_wr,
  input  logic [24:0]      ioctl_addr,
  input  logic [7:0]       ioctl_dout,
  output logic             ioctl_wait,
  output logic             rominit_active,
  output logic [REGIONS:0] rominit_sel,
  output logic [AW-1:0]    rominit_addr,
  output logic [7:0]       rominit_data,
  output logic             rominit_valid,
  input  logic             rominit_ready,
  output logic [AW:0]      cart_size,
  output logic             cart_size_valid,
  output logic             rominit_err
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [REGIONS:0] sel;
    logic [AW-1:0]    addr;
    logic [7:0]       data;
  } entry_t;

  // Cartridge bytes must lie below 2^AW.
  localparam logic [25:0] CART_LIMIT = 26'(1) << AW;

  state_t     state;
  logic       is_cart;
  logic [1:0] count;
  // slot0 is the head; slot1 is kept zero whenever it holds no entry so that
  // shifting it into the head on the last pop clears the outputs.
  entry_t     slot0;
  entry_t     slot1;

  entry_t     new_entry;
  logic       dec_ok;
  logic       wr_load;
  logic       deq;
  logic       enq;
  logic       drop;
  logic [AW:0] size_cand;

  function automatic logic [24:0] region_hi(int k);
    return REGION_END[k*25 +: 25];
  endfunction

  function automatic logic [24:0] region_lo(int k);
    int idx;
    idx = (k > 0) ? k - 1 : 0;
    return (k > 0) ? REGION_END[idx*25 +: 25] : 25'd0;
  endfunction

  // Address decode of the incoming byte into {sel, addr, data}.
  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    new_entry      = '0;
    new_entry.data = ioctl_dout;
    dec_ok         = 1'b0;
    if (is_cart) begin
      if ({1'b0, ioctl_addr} < CART_LIMIT) begin
        new_entry.sel[REGIONS] = 1'b1;
        new_entry.addr         = ioctl_addr[AW-1:0];
        dec_ok                 = 1'b1;
      end
    end else begin
      // Regions are disjoint, so at most one iteration matches.
      for (int k = 0; k < REGIONS; k++) begin
        if (ioctl_addr >= region_lo(k) && ioctl_addr < region_hi(k)) begin
          new_entry.sel[k] = 1'b1;
          new_entry.addr   = AW'(ioctl_addr - region_lo(k));
          dec_ok           = 1'b1;
        end
      end
    end
  end

  assign wr_load   = (state == LOAD) && ioctl_wr;
  assign deq       = (count != 2'd0) && rominit_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign enq       = wr_load && dec_ok && ((count != 2'd2) || deq);
  assign drop      = wr_load && !enq;
  assign size_cand = (AW+1)'(ioctl_addr[AW-1:0]) + (AW+1)'(1);

  assign ioctl_wait    = (count != 2'd0);
  assign rominit_valid = (count != 2'd0);
  assign rominit_sel   = slot0.sel;
  assign rominit_addr  = slot0.addr;
  assign rominit_data  = slot0.data;

  // NOTE: sequential state uses non-blocking assignments only; later
  // assignments in this block deliberately override earlier ones.
  always_ff @(posedge clk_sys) begin
    if (!resb) begin
      state           <= IDLE;
      is_cart         <= 1'b0;
      rominit_active  <= 1'b0;
      count           <= 2'd0;
      // NOTE: the FIFO slots drive the outputs directly, so they are reset too.
      slot0           <= '0;
      slot1           <= '0;
      cart_size       <= '0;
      cart_size_valid <= 1'b0;
      rominit_err     <= 1'b0;
    end else begin
      unique case ({enq, deq})
        2'b10: begin
          if (count == 2'd0) slot0 <= new_entry;
          else               slot1 <= new_entry;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          slot1 <= '0;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= new_entry;
          end else begin
            slot0 <= slot1;
            slot1 <= new_entry;
          end
        end
        default: ;
      endcase

      if (enq && is_cart && (size_cand > cart_size)) cart_size <= size_cand;
      if (drop) rominit_err <= 1'b1;

      case (state)
        IDLE: begin
          if (ioctl_download &&
              (ioctl_index == BOOT_INDEX || ioctl_index == CART_INDEX)) begin
            state          <= LOAD;
            rominit_active <= 1'b1;
            is_cart        <= (ioctl_index != BOOT_INDEX);
            rominit_err    <= 1'b0;
            if (ioctl_index != BOOT_INDEX) cart_size <= '0;
          end
        end
        LOAD: begin
          if (!ioctl_download) state <= DRAIN;
        end
        DRAIN: begin
          if (count == 2'd0) begin
            state           <= DONE;
            rominit_active  <= 1'b0;
            cart_size_valid <= is_cart;
          end
        end
        DONE: begin
          state           <= IDLE;
          cart_size_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader with default parameters: a queue-based
// reference model is compared against every output each cycle, and directed
// scenarios add hand-computed literal expectations.

module tb_rom_loader;

  logic        clk_sys = 1'b0;
  logic        resb;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        rominit_active;
  logic [3:0]  rominit_sel;
  logic [16:0] rominit_addr;
  logic [7:0]  rominit_data;
  logic        rominit_valid;
  logic        rominit_ready;
  logic [17:0] cart_size;
  logic        cart_size_valid;
  logic        rominit_err;

  rom_loader dut (
    .clk_sys         (clk_sys),
    .resb            (resb),
    .ioctl_download  (ioctl_download),
    .ioctl_index     (ioctl_index),
    .ioctl_wr        (ioctl_wr),
    .ioctl_addr      (ioctl_addr),
    .ioctl_dout      (ioctl_dout),
    .ioctl_wait      (ioctl_wait),
    .rominit_active  (rominit_active),
    .rominit_sel     (rominit_sel),
    .rominit_addr    (rominit_addr),
    .rominit_data    (rominit_data),
    .rominit_valid   (rominit_valid),
    .rominit_ready   (rominit_ready),
    .cart_size       (cart_size),
    .cart_size_valid (cart_size_valid),
    .rominit_err     (rominit_err)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int pulse_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit [3:0] sel;
    int       addr;
    bit [7:0] data;
  } exp_t;

  exp_t m_q[$];
  bit   m_loading, m_draining, m_done, m_cart, m_err;
  int   m_cart_size;

  // Boot bytes land in the first region whose end lies above the address;
  // cartridge bytes go straight through below 2^17.
  function automatic bit decode(input int a, input bit cart, output exp_t e);
    int bounds[3] = '{'h1000, 'h1400, 'h2400};
    int lo = 0;
    e.sel = 4'b0; e.addr = 0; e.data = 8'h0;
    if (cart) begin
      if (a < (1 << 17)) begin
        e.sel = 4'b1000; e.addr = a;
        return 1'b1;
      end
      return 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      if (a < bounds[k]) begin
        e.sel  = 4'(1 << k);
        e.addr = a - lo;
        return 1'b1;
      end
      lo = bounds[k];
    end
    return 1'b0;
  endfunction

  bit   s_deq, s_push, s_empty, s_ok;
  bit   s_loading, s_draining, s_done;
  exp_t s_e;

  always @(posedge clk_sys) begin
    if (!resb) begin
      m_q.delete();
      m_loading = 0; m_draining = 0; m_done = 0; m_cart = 0; m_err = 0;
      m_cart_size = 0;
    end else begin
      s_deq = (m_q.size() != 0) && rominit_ready;
      s_empty = (m_q.size() == 0);
      s_loading = m_loading; s_draining = m_draining; s_done = m_done;
      s_push = 0;
      if (m_loading && ioctl_wr) begin
        s_ok = decode(int'(ioctl_addr), m_cart, s_e);
        s_e.data = ioctl_dout;
        if (!s_ok || (m_q.size() == 2 && !s_deq)) begin
          m_err = 1;
        end else begin
          s_push = 1;
          if (m_cart && int'(ioctl_addr) + 1 > m_cart_size) m_cart_size = int'(ioctl_addr) + 1;
        end
      end
      if (s_deq) void'(m_q.pop_front());
      if (s_push) m_q.push_back(s_e);
      if (s_done) begin
        m_done = 0;
      end else if (s_draining) begin
        if (s_empty) begin m_draining = 0; m_done = 1; end
      end else if (s_loading) begin
        if (!ioctl_download) begin m_loading = 0; m_draining = 1; end
      end else if (ioctl_download && (ioctl_index == 8'd0 || ioctl_index == 8'd1)) begin
        m_loading = 1;
        m_cart = (ioctl_index == 8'd1);
        m_err = 0;
        if (m_cart) m_cart_size = 0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_sys) begin
    if (chk_en) begin
      check("wait",   ioctl_wait,     m_q.size() != 0);
      check("valid",  rominit_valid,  m_q.size() != 0);
      check("active", rominit_active, m_loading || m_draining);
      check("sel",    rominit_sel,    (m_q.size() != 0) ? m_q[0].sel : 4'b0);
      if (m_q.size() != 0) begin
        check("addr", rominit_addr, m_q[0].addr);
        check("data", rominit_data, m_q[0].data);
      end
      check("cart_size",       cart_size,       m_cart_size);
      check("cart_size_valid", cart_size_valid, m_done && m_cart);
      check("err",             rominit_err,     m_err);
      if (cart_size_valid === 1'b1) pulse_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_dl(input logic [7:0] idx);
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    ioctl_index    = idx;
    @(negedge clk_sys);
  endtask

  task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  // Drop DOWNLOAD and wait for ACTIVE to fall; returns in the DONE cycle.
  task automatic end_dl(input string name);
    bit seen = 0;
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_sys);
      if (rominit_active === 1'b0) begin seen = 1; break; end
    end
    check({name, "_drain_done"}, seen, 1'b1);
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    resb = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = 8'h0; rominit_ready = 1'b1;
    repeat (2) @(negedge clk_sys);
    chk_en = 1'b1;
    check("reset_active", rominit_active, 0);
    check("reset_wait",   ioctl_wait, 0);
    check("reset_size",   cart_size, 0);
    resb = 1'b1;

    // Boot decode across all three regions.
    start_dl(8'd0);
    write_byte(25'h0FFF, 8'hA1);
    check("boot0_sel", rominit_sel, 4'b0001);
    check("boot0_addr", rominit_addr, 17'h0FFF);
    check("boot0_data", rominit_data, 8'hA1);
    write_byte(25'h1000, 8'hA2);
    check("boot1_sel", rominit_sel, 4'b0010);
    check("boot1_addr", rominit_addr, 17'h0);
    write_byte(25'h23FF, 8'hA3);
    check("boot2_sel", rominit_sel, 4'b0100);
    check("boot2_addr", rominit_addr, 17'h0FFF);
    end_dl("boot");
    check("boot_err", rominit_err, 0);
    check("boot_no_size_pulse", cart_size_valid, 0);
    @(negedge clk_sys);

    // Cartridge of 0x2000 bytes, one per cycle.
    pulse_cnt = 0;
    start_dl(8'd1);
    for (int i = 0; i < 'h2000; i++) begin
      @(negedge clk_sys);
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'(i) ^ 8'h5A;
    end
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    end_dl("cart");
    check("cart_size_done", cart_size, 18'h2000);
    check("cart_pulse_done", cart_size_valid, 1);
    repeat (3) @(negedge clk_sys);
    check("cart_pulse_count", pulse_cnt, 1);
    check("cart_size_hold", cart_size, 18'h2000);

    // Backpressure, overflow drop, ordered drain.
    rominit_ready = 1'b0;
    start_dl(8'd0);
    write_byte(25'h10, 8'h11);
    write_byte(25'h11, 8'h22);
    check("full_wait", ioctl_wait, 1);
    check("full_head", rominit_data, 8'h11);
    write_byte(25'h12, 8'h33);
    check("overflow_err", rominit_err, 1);
    check("overflow_head", rominit_data, 8'h11);
    rominit_ready = 1'b1;
    @(negedge clk_sys);
    check("pop1_data", rominit_data, 8'h22);
    check("pop1_addr", rominit_addr, 17'h11);
    @(negedge clk_sys);
    check("pop2_wait", ioctl_wait, 0);
    check("pop2_sel", rominit_sel, 4'b0);
    end_dl("ovf");
    @(negedge clk_sys);

    // Out-of-range boot byte and an unhandled index.
    start_dl(8'd0);
    write_byte(25'h2400, 8'h77);
    check("oor_valid", rominit_valid, 0);
    check("oor_err", rominit_err, 1);
    end_dl("oor");
    @(negedge clk_sys);
    ioctl_download = 1'b1; ioctl_index = 8'd5;
    repeat (3) @(negedge clk_sys);
    check("idx5_active", rominit_active, 0);
    ioctl_download = 1'b0;
    @(negedge clk_sys);

    // DRAIN holds ACTIVE until the queued bytes are consumed.
    start_dl(8'd0);
    check("new_load_err_clear", rominit_err, 0);
    rominit_ready = 1'b0;
    write_byte(25'h20, 8'hB1);
    write_byte(25'h21, 8'hB2);
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    repeat (3) begin
      @(negedge clk_sys);
      check("drain_active", rominit_active, 1);
    end
    rominit_ready = 1'b1;
    end_dl("drain");
    @(negedge clk_sys);

    // Reset mid-load with a full FIFO, DOWNLOAD held through reset.
    start_dl(8'd1);
    rominit_ready = 1'b0;
    write_byte(25'h30, 8'hC1);
    write_byte(25'h31, 8'hC2);
    check("pre_reset_size", cart_size, 18'h32);
    resb = 1'b0;
    @(negedge clk_sys);
    check("rst_wait", ioctl_wait, 0);
    check("rst_active", rominit_active, 0);
    check("rst_sel", rominit_sel, 0);
    check("rst_addr", rominit_addr, 0);
    check("rst_data", rominit_data, 0);
    check("rst_size", cart_size, 0);
    resb = 1'b1;
    rominit_ready = 1'b1;
    @(negedge clk_sys);
    check("post_reset_active", rominit_active, 1);
    write_byte(25'h5, 8'hD1);
    end_dl("post_reset");
    check("post_reset_size", cart_size, 18'h6);
    repeat (2) @(negedge clk_sys);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
